shift_amt_engine: RTL and testbench
===================================

# shift_amt_engine

Parametrised multi-cycle shifter for the datapath. It selects the shift amount from one of four sources: register B, the instruction shamt field, the extended offset, or a constant for LUI. It then performs the shift or rotate iteratively, at most STEP bit positions per clock. It sits between the register-file/extender outputs and the ALU-result mux, and the control unit drives it with a start/done handshake.

## Interface
- WIDTH, 32: data width. Must be a power of two and at least 8.
- SA_W, $clog2(WIDTH): shift-amount width.
- STEP, 8: maximum positions shifted per cycle. Must be a power of two with 1 ≤ STEP ≤ WIDTH.
- CONST_AMT, 16: amount used when amt_sel = 3.
- clk  in  1  clock. All state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request pulse. Sampled only in IDLE.
- op  in  2  0 = SLL, 1 = SRL, 2 = SRA, 3 = ROR.
- amt_sel  in  2  0 = reg_b, 1 = shamt, 2 = ext_offset, 3 = CONST_AMT.
- data_in  in  WIDTH  operand to shift.
- reg_b  in  WIDTH  register B; low SA_W bits used.
- shamt  in  5  instruction shamt field. Zero-extended or truncated to SA_W.
- ext_offset  in  WIDTH  sign-extended offset; low SA_W bits used.
- data_out  out  WIDTH  result register.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  single-cycle completion strobe.

## Operation
- States are IDLE, SHIFT and DONE.
- **IDLE:**
  - On start = 1, latch data_in into the working register (data_out), latch op, and latch the selected amount into rem (SA_W bits).
  - Go to SHIFT.
  - Without start, hold everything.
- **SHIFT, rem ≠ 0:**
  - Let k = min(rem, STEP).
  - Apply op by k to the working register: SLL/SRL fill with zeros, SRA fills with the current MSB, ROR rotates right.
  - rem ← rem − k. Stay in SHIFT.
- **SHIFT, rem = 0:** go to DONE. No data change.
- **DONE:** done = 1 for exactly this cycle, then go to IDLE.
- Amount rule: the selected source is truncated to its low SA_W bits (mod WIDTH shift, MIPS semantics). CONST_AMT is truncated the same way.
- start is ignored in SHIFT and DONE. A request is never queued.
- data_out holds the last result until the next accepted start. It then shows intermediate values during SHIFT.
- Inputs other than start are don't-care after the accept edge.
- Output defaults:
  - done = 0 outside DONE.
  - busy is combinational from state: 1 in SHIFT and DONE, 0 in IDLE.
- Asynchronous reset (reset = 0), at any time including mid-shift:
  - state = IDLE, data_out = 0, rem = 0, latched op = 0, done = 0, busy = 0.
  - After reset deasserts, the first rising edge may accept a start.

## Timing
- The accept edge is E0.
- Shift edges are E1 through EN, where N = ceil(amt / STEP). N = 0 when amt = 0.
- E(N+1) enters DONE, so done is high in the cycle after E(N+1).
- Latency from accept edge to done-high cycle is N + 1 edges. For WIDTH = 32 and STEP = 8 this is 1 to 5.
- busy rises the cycle after E0 and falls the cycle after done.
- The earliest back-to-back start is the first cycle with busy = 0. That start is accepted on its edge.
- data_out is final and stable from the done cycle onward.

## Test plan
- **SLL from shamt** (WIDTH = 32, STEP = 8): data_in = 0x0000_0001, op = 0, amt_sel = 1, shamt = 4.
  - Expect done 2 edges after accept and data_out = 0x0000_0010.
- **SRA with truncation from reg_b:** data_in = 0x8000_0000, op = 2, amt_sel = 0, reg_b = 35 (so amt = 3).
  - Expect data_out = 0xF000_0000 and done 2 edges after accept.
- **Maximum amount via ext_offset:** ext_offset = 0xFFFF_FFFF (amt = 31), data_in = 0x8000_0000, op = 1.
  - Expect data_out = 0x0000_0001.
  - Expect the step sequence 8, 8, 8, 7 and done 5 edges after accept.
- **LUI constant and rotate:**
  - amt_sel = 3, op = 0, data_in = 0x0000_1234 gives 0x1234_0000.
  - op = 3, amt_sel = 1, shamt = 8, data_in = 0x1234_5678 gives 0x7812_3456.
- **Zero amount and ignored start:** shamt = 0, data_in = 0xDEAD_BEEF.
  - Expect done 1 edge after accept and data_out = 0xDEAD_BEEF.
  - A second start pulsed while busy = 1 is ignored: exactly one done pulse, result unchanged.
- **Reset mid-operation:** assert reset = 0 asynchronously during SHIFT of a 31-bit shift.
  - Expect data_out = 0, busy = 0, done = 0 immediately, with no done pulse afterwards.
  - A fresh start after release completes normally.

Source files
------------

// File: rtl/shift_amt_engine_if.sv
// Request/response bundle between the control unit and the shift engine.
interface shift_amt_engine_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             start;
  logic [1:0]       op;
  logic [1:0]       amt_sel;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] reg_b;
  logic [4:0]       shamt;
  logic [WIDTH-1:0] ext_offset;
  logic [WIDTH-1:0] data_out;
  logic             busy;
  logic             done;

  // Control-unit side: issues requests, observes result and status.
  modport master (
    output start, op, amt_sel, data_in, reg_b, shamt, ext_offset,
    input  data_out, busy, done
  );

  // Engine side.
  modport slave (
    input  start, op, amt_sel, data_in, reg_b, shamt, ext_offset,
    output data_out, busy, done
  );

endinterface

// File: rtl/shift_amt_engine.sv
// Iterative shifter/rotator: moves at most STEP bit positions per clock,
// amount taken mod WIDTH from one of four sources.
module shift_amt_engine #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned SA_W      = $clog2(WIDTH),
  parameter int unsigned STEP      = 8,
  parameter int unsigned CONST_AMT = 16
) (
  input  logic                clk,
  input  logic                reset,
  shift_amt_engine_if.slave   bus
);

  // One extra bit so STEP == WIDTH is representable in the per-cycle amount.
  localparam int unsigned    KW       = SA_W + 1;
  localparam logic [KW-1:0]  STEP_K   = KW'(STEP);
  localparam logic [KW-1:0]  WIDTH_K  = KW'(WIDTH);
  localparam logic [SA_W-1:0] CONST_SA = SA_W'(CONST_AMT);

  localparam logic [1:0] OP_SLL = 2'd0;
  localparam logic [1:0] OP_SRL = 2'd1;
  localparam logic [1:0] OP_SRA = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [SA_W-1:0]  rem_q,   rem_d;
  logic [1:0]       op_q,    op_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  logic [SA_W-1:0]  sel_amt;
  logic [KW-1:0]    rem_ext;
  logic [KW-1:0]    step_k;
  logic [WIDTH-1:0] shifted;

  // Upper operand bits are intentionally ignored (amount is mod WIDTH).
  logic unused_bits;
  assign unused_bits = ^{bus.reg_b[WIDTH-1:SA_W], bus.ext_offset[WIDTH-1:SA_W]};

  // Amount source select, truncated to SA_W bits.
  always_comb begin
    sel_amt = '0;
    unique case (bus.amt_sel)
      2'd0:    sel_amt = bus.reg_b[SA_W-1:0];
      2'd1:    sel_amt = SA_W'(bus.shamt);
      2'd2:    sel_amt = bus.ext_offset[SA_W-1:0];
      default: sel_amt = CONST_SA;
    endcase
  end

  // Per-cycle step k = min(rem, STEP) and the working value shifted by k.
  always_comb begin
    rem_ext = {1'b0, rem_q};
    step_k  = (rem_ext < STEP_K) ? rem_ext : STEP_K;
    shifted = data_q;
    unique case (op_q)
      OP_SLL:  shifted = data_q << step_k;
      OP_SRL:  shifted = data_q >> step_k;
      OP_SRA:  shifted = WIDTH'($signed(data_q) >>> step_k);
      default: shifted = (data_q >> step_k) | (data_q << (WIDTH_K - step_k));
    endcase
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    op_d    = op_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          data_d  = bus.data_in;
          op_d    = bus.op;
          rem_d   = sel_amt;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (rem_q != '0) begin
          data_d = shifted;
          rem_d  = rem_q - SA_W'(step_k);
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      op_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.data_out = data_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_shift_amt_engine.sv
// Bench for shift_amt_engine: vector table plus scoreboard of expected results.
module tb_shift_amt_engine;

  localparam int unsigned WIDTH = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shift_amt_engine_if #(.WIDTH(WIDTH)) bus ();

  shift_amt_engine #(
    .WIDTH(WIDTH), .STEP(8), .CONST_AMT(16)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  amt_sel;
    logic [31:0] data_in;
    logic [31:0] reg_b;
    logic [31:0] ext_offset;
    logic [4:0]  shamt;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    int          lat;
    int          acc;
    int          idx;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[13];
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no request pending", cyc);
      end else begin
        e = sb.pop_front();
        check32($sformatf("vec%0d_data", e.idx), bus.data_out, e.data);
        check32($sformatf("vec%0d_latency", e.idx), 32'(cyc - e.acc), 32'(e.lat));
      end
    end
  end

  // Issue one request; returns at the negedge right after the accept edge.
  task automatic drive(input vec_t v, input int idx);
    exp_t e;
    int   n;
    @(negedge clk);
    n = 0;
    while (bus.busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    bus.op         = v.op;
    bus.amt_sel    = v.amt_sel;
    bus.data_in    = v.data_in;
    bus.reg_b      = v.reg_b;
    bus.ext_offset = v.ext_offset;
    bus.shamt      = v.shamt;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start      = 1'b0;
    bus.op         = 2'($urandom);
    bus.amt_sel    = 2'($urandom);
    bus.data_in    = $urandom;
    bus.reg_b      = $urandom;
    bus.ext_offset = $urandom;
    bus.shamt      = 5'($urandom);
    e.data = v.exp_data;
    e.lat  = v.exp_lat;
    e.acc  = cyc;
    e.idx  = idx;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.busy) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got still busy after %0d cycles, expected idle", name, n);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;

    vecs[0]  = '{2'd0, 2'd1, 32'h0000_0001, 32'h0,  32'h0,         5'd4,  32'h0000_0010, 2};
    vecs[1]  = '{2'd2, 2'd0, 32'h8000_0000, 32'd35, 32'h0,         5'd0,  32'hF000_0000, 2};
    vecs[2]  = '{2'd1, 2'd2, 32'h8000_0000, 32'h0,  32'hFFFF_FFFF, 5'd0,  32'h0000_0001, 5};
    vecs[3]  = '{2'd0, 2'd3, 32'h0000_1234, 32'h0,  32'h0,         5'd0,  32'h1234_0000, 3};
    vecs[4]  = '{2'd3, 2'd1, 32'h1234_5678, 32'h0,  32'h0,         5'd8,  32'h7812_3456, 2};
    vecs[5]  = '{2'd0, 2'd1, 32'hDEAD_BEEF, 32'h0,  32'h0,         5'd0,  32'hDEAD_BEEF, 1};
    vecs[6]  = '{2'd3, 2'd0, 32'h8000_0001, 32'd31, 32'h0,         5'd0,  32'h0000_0003, 5};
    vecs[7]  = '{2'd2, 2'd2, 32'h7F00_0000, 32'h0,  32'h0000_000C, 5'd0,  32'h0007_F000, 3};
    vecs[8]  = '{2'd0, 2'd1, 32'hFFFF_FFFF, 32'h0,  32'h0,         5'd31, 32'h8000_0000, 5};
    vecs[9]  = '{2'd1, 2'd1, 32'hABCD_1234, 32'h0,  32'h0,         5'd16, 32'h0000_ABCD, 3};
    vecs[10] = '{2'd2, 2'd0, 32'h8000_0000, 32'h20, 32'h0,         5'd0,  32'h8000_0000, 1};
    vecs[11] = '{2'd3, 2'd3, 32'h1234_5678, 32'h0,  32'h0,         5'd0,  32'h5678_1234, 3};
    vecs[12] = '{2'd2, 2'd1, 32'h8000_1234, 32'h0,  32'h0,         5'd9,  32'hFFC0_0009, 3};

    bus.start = 1'b0; bus.op = '0; bus.amt_sel = '0;
    bus.data_in = '0; bus.reg_b = '0; bus.ext_offset = '0; bus.shamt = '0;

    // Reset state.
    #12;
    check32("reset_data_out", bus.data_out, 32'h0);
    check32("reset_busy", 32'(bus.busy), 32'h0);
    check32("reset_done", 32'(bus.done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors, back to back.
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i], i);
      wait_idle($sformatf("vec%0d", i));
    end

    // Step sequence 8,8,8,7 for a 31-bit SRL.
    drive(vecs[2], 102);
    check32("step_e0", bus.data_out, 32'h8000_0000);
    @(negedge clk); check32("step_e1", bus.data_out, 32'h0080_0000);
    @(negedge clk); check32("step_e2", bus.data_out, 32'h0000_8000);
    @(negedge clk); check32("step_e3", bus.data_out, 32'h0000_0080);
    @(negedge clk); check32("step_e4", bus.data_out, 32'h0000_0001);
    wait_idle("step_seq");
    check32("hold_after_done", bus.data_out, 32'h0000_0001);
    check32("busy_after_done", 32'(bus.busy), 32'h0);

    // Start pulsed while busy is ignored.
    d0 = done_cnt;
    drive(vecs[5], 105);
    check32("busy_after_accept", 32'(bus.busy), 32'h1);
    bus.start   = 1'b1;
    bus.data_in = 32'h1111_1111;
    bus.shamt   = 5'd3;
    @(negedge clk);
    bus.start   = 1'b0;
    repeat (6) @(negedge clk);
    wait_idle("ignored_start");
    check32("ignored_start_done_count", 32'(done_cnt - d0), 32'd1);
    check32("ignored_start_data", bus.data_out, 32'hDEAD_BEEF);

    // Asynchronous reset mid-shift.
    drive(vecs[2], 202);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check32("midrst_data_out", bus.data_out, 32'h0);
    check32("midrst_busy", 32'(bus.busy), 32'h0);
    check32("midrst_done", 32'(bus.done), 32'h0);
    sb.delete();
    d0 = done_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check32("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    check32("midrst_idle", 32'(bus.busy), 32'h0);

    // Fresh request after reset completes normally.
    drive(vecs[4], 204);
    wait_idle("post_reset");
    check32("post_reset_done_count", 32'(done_cnt - d0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
